// File: rtl/add_arb_seq_pkg.sv
// Shared types for the two-requester sequential adder: FSM states, requester ids,
// and the slice-index width helper.
package add_arb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // A single-slice adder still needs a 1-bit index register.
  function automatic int slice_idx_w(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/add_arb_seq_csa_2.sv
// 2-bit carry-select adder slice: both carry-in outcomes are precomputed and
// the real carry-in picks one.
module add_arb_seq_csa_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [1:0] sum
);

  logic [2:0] sum_c0;
  logic [2:0] sum_c1;

  assign sum_c0      = {1'b0, a} + {1'b0, b};
  assign sum_c1      = sum_c0 + 3'd1;
  assign {cout, sum} = cin ? sum_c1 : sum_c0;

endmodule

// File: rtl/add_arb_seq.sv
// Two-requester round-robin adder that processes WIDTH/2 two-bit slices, one per cycle.
// Optional subtract mode with ADD_ARB_SEQ_SUB_EN (adds req0_sub/req1_sub ports).
module add_arb_seq
  import add_arb_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
`ifdef ADD_ARB_SEQ_SUB_EN
  input  logic             req0_sub,
  input  logic             req1_sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 2;
  localparam int KW = slice_idx_w(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  req_id_t          id_q, id_d;
  req_id_t          prio_q, prio_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic             grant0, grant1;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin;
  logic [1:0]       sl_a, sl_b, sl_sum;
  logic             sl_cout;

  // prio_q names the requester that wins a tie; it flips to the other side after every grant.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (prio_q == REQ0));
    grant1 = req1_valid && !grant0;
  end

  assign req0_ready = (state_q == IDLE) && !reset && grant0;
  assign req1_ready = (state_q == IDLE) && !reset && grant1;

  always_comb begin
    sel_a   = grant1 ? req1_a   : req0_a;
    sel_b   = grant1 ? req1_b   : req0_b;
    sel_cin = grant1 ? req1_cin : req0_cin;
`ifdef ADD_ARB_SEQ_SUB_EN
    // a - b computed as a + ~b + 1; carry-out high means no borrow.
    if (grant1 ? req1_sub : req0_sub) begin
      sel_b   = ~sel_b;
      sel_cin = 1'b1;
    end
`endif
  end

  always_comb begin
    sl_a = 2'b00;
    sl_b = 2'b00;
    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        sl_a = a_q[2*i +: 2];
        sl_b = b_q[2*i +: 2];
      end
    end
  end

  add_arb_seq_csa_2 u_csa (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .cout (sl_cout),
    .sum  (sl_sum)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    id_d        = id_q;
    prio_d      = prio_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_d     = sel_a;
          b_d     = sel_b;
          carry_d = sel_cin;
          k_d     = '0;
          id_d    = grant1 ? REQ1 : REQ0;
          prio_d  = grant1 ? REQ0 : REQ1;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[2*i +: 2] = sl_sum;
          end
        end
        carry_d = sl_cout;
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d     = DONE;
          k_d         = '0;
          cout_d      = sl_cout;
          rsp_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      id_q        <= REQ0;
      prio_q      <= REQ0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      id_q        <= id_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_add_arb_seq.sv
// Bench for add_arb_seq (WIDTH=8): directed cases plus random traffic against an
// arithmetic reference model with round-robin arbitration.
module tb_add_arb_seq;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
`ifdef ADD_ARB_SEQ_SUB_EN
  logic         req0_sub, req1_sub;
`endif
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  int checks = 0;
  int errors = 0;
  int last_grant;
  int got_id;

  add_arb_seq #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
`ifdef ADD_ARB_SEQ_SUB_EN
    .req0_sub   (req0_sub),
    .req1_sub   (req1_sub),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 2ns after the rising edge; outputs sampled 1ns later.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("ready_in_reset", {req0_ready, req1_ready}, 2'b00);
    tick();
    reset = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", rsp_sum, 0);
    check("rst_cout", rsp_cout, 1'b0);
    check("rst_id", rsp_id, 1'b0);
    last_grant = 1;
  endtask

  // One full transaction: grant, W/2-cycle compute, hold cycles of backpressure, handshake.
  task automatic do_op(input int hold, input bit keep, output int id_seen);
    int exp_id, lat;
    logic [W-1:0] ea, eb;
    logic         ec;
    logic [W:0]   full;
    if (req0_valid && req1_valid) exp_id = 1 - last_grant;
    else exp_id = req0_valid ? 0 : 1;
    #1;
    check("ready0", req0_ready, exp_id == 0);
    check("ready1", req1_ready, exp_id == 1);
    ea = exp_id == 0 ? req0_a : req1_a;
    eb = exp_id == 0 ? req0_b : req1_b;
    ec = exp_id == 0 ? req0_cin : req1_cin;
`ifdef ADD_ARB_SEQ_SUB_EN
    if (exp_id == 0 ? req0_sub : req1_sub) begin
      eb = ~eb;
      ec = 1'b1;
    end
`endif
    full = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    last_grant = exp_id;
    tick();
    if (!keep) begin
      if (exp_id == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
    lat = 0;
    #1;
    while (!rsp_valid && lat < 20) begin
      check("run_busy", busy, 1'b1);
      check("run_readys", {req0_ready, req1_ready}, 2'b00);
      tick();
      lat++;
      #1;
    end
    check("latency", lat, W / 2);
    for (int i = 0; i <= hold; i++) begin
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_sum", rsp_sum, full[W-1:0]);
      check("rsp_cout", rsp_cout, full[W]);
      check("rsp_id", rsp_id, exp_id);
      check("done_readys", {req0_ready, req1_ready}, 2'b00);
      check("done_busy", busy, 1'b1);
      if (i < hold) begin
        tick();
        #1;
      end
    end
    id_seen = rsp_id;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("post_valid", rsp_valid, 1'b0);
    check("post_busy", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_a = 0; req1_b = 0; req1_cin = 0;
`ifdef ADD_ARB_SEQ_SUB_EN
    req0_sub = 0; req1_sub = 0;
`endif
    tick();
    apply_reset();
    check("idle_readys", {req0_ready, req1_ready}, 2'b00);

    // Single add on req0, then carry ripple on req1.
    req0_valid = 1; req0_a = 8'hA5; req0_b = 8'h5B; req0_cin = 0;
    do_op(0, 0, got_id);
    req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h00; req1_cin = 1;
    do_op(0, 0, got_id);
    check("ripple_id", got_id, 1);

    // Contention from reset: strict alternation starting with req0.
    apply_reset();
    req0_valid = 1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cin = 1'($urandom);
    req1_valid = 1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cin = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1, got_id);
      check("contention_order", got_id, i % 2);
    end
    req0_valid = 0; req1_valid = 0;

    // Backpressure for 10 cycles with req1 waiting; req1 then serviced first.
    req0_valid = 1; req0_a = 8'h3C; req0_b = 8'hC4; req0_cin = 1;
    req1_valid = 1; req1_a = 8'h80; req1_b = 8'h80; req1_cin = 0;
    do_op(10, 0, got_id);
    do_op(0, 0, got_id);
    check("pending_served", got_id, 1);

    // Reset at k=2, with a valid request coinciding with reset.
    req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34; req0_cin = 0;
    #1;
    check("pre_abort_ready", req0_ready, 1'b1);
    tick(); tick(); tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 8'h7F; req1_b = 8'h01; req1_cin = 0;
    apply_reset();
    do_op(0, 0, got_id);
    check("after_abort_id", got_id, 1);

    // Reset in IDLE with a request valid: request must not start an operation.
    req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h0F; req0_cin = 1;
    apply_reset();
    do_op(1, 0, got_id);

`ifdef ADD_ARB_SEQ_SUB_EN
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h01; req0_sub = 1;
    do_op(0, 0, got_id);
    check("sub_nb_sum", rsp_sum, 8'h0F);
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_sub = 1;
    do_op(0, 0, got_id);
    check("sub_borrow_sum", rsp_sum, 8'hFF);
    check("sub_borrow_cout", rsp_cout, 1'b0);
    req0_sub = 0;
`endif

    // Random traffic: unserved requester keeps its operands until granted.
    for (int n = 0; n < 40; n++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cin = 1'($urandom);
`ifdef ADD_ARB_SEQ_SUB_EN
        req0_sub = 1'($urandom);
`endif
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cin = 1'($urandom);
`ifdef ADD_ARB_SEQ_SUB_EN
        req1_sub = 1'($urandom);
`endif
      end
      if (!req0_valid && !req1_valid) begin
        req0_valid = 1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cin = 1'($urandom);
      end
      do_op($urandom_range(0, 3), 0, got_id);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
